// File: rtl/xtimer_bank.sv
// xtimer_bank: bank of NCH independent down-counting timers, each with its own prescaler.
// Each channel has a reload value, a one-shot or periodic mode, and a sticky terminal-count
// flag that is cleared by writing 1 to it.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-low reset
//   sel       block selected by the external address decoder
//   we, re    write / read strobes; both are ignored unless sel=1
//   addr      {channel, reg[1:0]}; reg 0=LOAD, 1=CTRL, 2=COUNT, 3=STATUS
//   data_in   write data
//   data_out  registered read data
//   tc        sticky terminal-count flag per channel (STATUS bit0)
//   tc_pulse  one-cycle pulse per channel on each terminal count
//
// Bus semantics: there is no handshake. A cycle with sel&we is a write that takes effect at
// the next clock edge. A cycle with sel&re is a read: data_out shows the register value seen
// in that cycle one clock later, and keeps it until the next read.
module xtimer_bank #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 16,
  parameter int PRE_W  = 8,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(NCH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [NCH-1:0]    tc,
  output logic [NCH-1:0]    tc_pulse
);

  localparam int CHW = (AW > 2) ? AW - 2 : 1;
  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [CNT_W-1:0]  load_q  [NCH];
  logic [CNT_W-1:0]  load_d  [NCH];
  logic [CNT_W-1:0]  count_q [NCH];
  logic [CNT_W-1:0]  count_d [NCH];
  logic [PRE_W-1:0]  pre_q   [NCH];
  logic [PRE_W-1:0]  pre_d   [NCH];
  logic [PRE_W-1:0]  psc_q   [NCH];
  logic [PRE_W-1:0]  psc_d   [NCH];
  logic [NCH-1:0]    en_q, en_d, per_q, per_d, tc_q, tc_d, tc_pulse_q, tc_pulse_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic [CHW-1:0] acc_ch;
  logic [1:0]     acc_reg;
  logic           ch_valid;
  logic           wr_en;
  logic [NCH-1:0] wr_hit, wr_load, wr_ctrl, wr_stat, tick;

  // With a single channel the address holds only the register field.
  generate
    if (AW > 2) begin : g_ch_field
      assign acc_ch = addr[AW-1:2];
    end else begin : g_no_ch_field
      assign acc_ch = '0;
    end
  endgenerate

  assign acc_reg  = addr[1:0];
  assign ch_valid = (int'(acc_ch) < NCH);
  assign wr_en    = sel && we && ch_valid;

  always_comb begin
    wr_hit  = '0;
    wr_load = '0;
    wr_ctrl = '0;
    wr_stat = '0;
    tick    = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i]  = wr_en && (int'(acc_ch) == i);
      wr_load[i] = wr_hit[i] && (acc_reg == REG_LOAD);
      wr_ctrl[i] = wr_hit[i] && (acc_reg == REG_CTRL);
      wr_stat[i] = wr_hit[i] && (acc_reg == REG_STATUS) && data_in[0];
      tick[i]    = en_q[i] && (psc_q[i] == pre_q[i]);
    end
  end

  // Per-channel next state. A LOAD or CTRL write to a channel takes priority over that
  // channel's tick in the same cycle: the write defines the new state and the tick is dropped.
  // A TC set in the same cycle as a write-1-clear wins, because the set is applied last.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      load_d[i]     = load_q[i];
      count_d[i]    = count_q[i];
      pre_d[i]      = pre_q[i];
      psc_d[i]      = psc_q[i];
      en_d[i]       = en_q[i];
      per_d[i]      = per_q[i];
      tc_d[i]       = tc_q[i];
      tc_pulse_d[i] = 1'b0;

      if (en_q[i]) begin
        psc_d[i] = tick[i] ? '0 : psc_q[i] + 1'b1;
      end

      if (wr_stat[i]) begin
        tc_d[i] = 1'b0;
      end

      if (wr_load[i]) begin
        load_d[i]  = data_in[CNT_W-1:0];
        count_d[i] = data_in[CNT_W-1:0];
        psc_d[i]   = '0;
      end else if (wr_ctrl[i]) begin
        en_d[i]  = data_in[0];
        per_d[i] = data_in[1];
        pre_d[i] = data_in[PRE_W+1:2];
        psc_d[i] = '0;
      end else if (tick[i]) begin
        if (count_q[i] != '0) begin
          count_d[i] = count_q[i] - 1'b1;
        end else begin
          tc_d[i]       = 1'b1;
          tc_pulse_d[i] = 1'b1;
          if (per_q[i]) begin
            count_d[i] = load_q[i];
          end else begin
            en_d[i]  = 1'b0;
            psc_d[i] = '0;
          end
        end
      end
    end
  end

  // Read data is captured from the values present in the read cycle.
  always_comb begin
    data_out_d = data_out_q;
    if (sel && re) begin
      data_out_d = '0;
      if (ch_valid) begin
        case (acc_reg)
          REG_LOAD:   data_out_d[CNT_W-1:0] = load_q[acc_ch];
          REG_CTRL: begin
            data_out_d[0]         = en_q[acc_ch];
            data_out_d[1]         = per_q[acc_ch];
            data_out_d[PRE_W+1:2] = pre_q[acc_ch];
          end
          REG_COUNT:  data_out_d[CNT_W-1:0] = count_q[acc_ch];
          REG_STATUS: data_out_d[0]         = tc_q[acc_ch];
          default:    data_out_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        load_q[i]  <= '0;
        count_q[i] <= '0;
        pre_q[i]   <= '0;
        psc_q[i]   <= '0;
      end
      en_q       <= '0;
      per_q      <= '0;
      tc_q       <= '0;
      tc_pulse_q <= '0;
      data_out_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        load_q[i]  <= load_d[i];
        count_q[i] <= count_d[i];
        pre_q[i]   <= pre_d[i];
        psc_q[i]   <= psc_d[i];
      end
      en_q       <= en_d;
      per_q      <= per_d;
      tc_q       <= tc_d;
      tc_pulse_q <= tc_pulse_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign tc       = tc_q;
  assign tc_pulse = tc_pulse_q;

endmodule
